// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a ready/req data-memory handshake,
// load lane extraction with sign/zero extension, store lane replication,
// misalignment detection and the MEM/WB pipeline register.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT-state timeout that
// aborts the access and raises bus_err. The default build has no timeout.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out_m,
    input  logic [31:0] store_data_m,
    input  logic [1:0]  L_type_m,
    input  logic [1:0]  S_type_m,
    input  logic        load_unsigned_m,
    input  logic        MemRead_m,
    input  logic        MemWrite_m,
    input  logic        regWrite_m,
    input  logic        MemToReg_m,
    input  logic [4:0]  Rd_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_M,
    output logic [31:0] read_data_W,
    output logic [31:0] alu_out_W,
    output logic [4:0]  Rd_W,
    output logic        regWrite_W,
    output logic        MemToReg_W,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_access;
    logic        w_rd_en;
    logic [1:0]  w_off;
    logic [1:0]  w_size;
    logic        w_misalign;
    logic        w_misalign_fault;
    logic        w_complete;
    logic        w_abort;
    logic        w_timeout;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    // A write wins over a simultaneous read; the read data is then discarded.
    assign w_access = MemRead_m | MemWrite_m;
    assign w_rd_en  = MemRead_m & ~MemWrite_m;
    assign w_off    = alu_out_m[1:0];
    assign w_size   = MemWrite_m ? S_type_m : L_type_m;

    // Half needs 2-byte alignment; word (and the 11 encoding) needs 4-byte.
    assign w_misalign = ((w_size == SZ_HALF) && w_off[0]) ||
                        (w_size[1] && (w_off != 2'b00));

    assign dmem_addr = {alu_out_m[31:2], 2'b00};
    assign dmem_we   = dmem_req & MemWrite_m;

    // Store lane replication and byte enables.
    always_comb begin
        dmem_wdata = store_data_m;
        dmem_be    = 4'b1111;
        case (w_size)
            SZ_BYTE: begin
                dmem_wdata = {4{store_data_m[7:0]}};
                dmem_be    = 4'b0001 << w_off;
            end
            SZ_HALF: begin
                dmem_wdata = {2{store_data_m[15:0]}};
                dmem_be    = 4'b0011 << {w_off[1], 1'b0};
            end
            default: begin
                dmem_wdata = store_data_m;
                dmem_be    = 4'b1111;
            end
        endcase
    end

    // Load lane select followed by sign or zero extension.
    assign w_shifted = dmem_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load_data = dmem_rdata;
        case (L_type_m)
            SZ_BYTE: w_load_data = load_unsigned_m ? {24'd0, w_shifted[7:0]}
                                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: w_load_data = load_unsigned_m ? {16'd0, w_shifted[15:0]}
                                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = dmem_rdata;
        endcase
    end

    // Handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, bus request and stall.
    always_comb begin
        w_state_next     = r_state;
        dmem_req         = 1'b0;
        stall_M          = 1'b0;
        w_complete       = 1'b0;
        w_abort          = 1'b0;
        w_misalign_fault = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (w_misalign) begin
                        w_misalign_fault = 1'b1;
                    end else begin
                        dmem_req = 1'b1;
                        if (dmem_ready) begin
                            w_complete = 1'b1;
                        end else begin
                            stall_M      = 1'b1;
                            w_state_next = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    stall_M = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [3:0] r_cnt;

    // The 15th WAIT cycle without ready is the one that would bring the count to 15.
    assign w_timeout = (r_cnt == 4'd14);

    // WAIT-cycle counter and registered bus fault pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= w_abort;
            if ((r_state == S_WAIT) && !w_complete && !w_abort) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // MEM/WB register: bubble on stall or fault, otherwise pass the instruction through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_W  <= 32'd0;
            alu_out_W    <= 32'd0;
            Rd_W         <= 5'd0;
            regWrite_W   <= 1'b0;
            MemToReg_W   <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= w_misalign_fault;
            if (stall_M || w_misalign_fault || w_abort) begin
                regWrite_W <= 1'b0;
                MemToReg_W <= 1'b0;
            end else begin
                alu_out_W  <= alu_out_m;
                Rd_W       <= Rd_M;
                regWrite_W <= regWrite_m;
                MemToReg_W <= MemToReg_m;
                if (w_complete && w_rd_en) begin
                    read_data_W <= w_load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change on the falling edge,
// combinational outputs are checked just after that, registered outputs
// just after the following rising edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_out_m;
    logic [31:0] store_data_m;
    logic [1:0]  L_type_m;
    logic [1:0]  S_type_m;
    logic        load_unsigned_m;
    logic        MemRead_m;
    logic        MemWrite_m;
    logic        regWrite_m;
    logic        MemToReg_m;
    logic [4:0]  Rd_M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        stall_M;
    logic [31:0] read_data_W;
    logic [31:0] alu_out_W;
    logic [4:0]  Rd_W;
    logic        regWrite_W;
    logic        MemToReg_W;
    logic        misalign_err;
    logic        bus_err;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .alu_out_m       (alu_out_m),
        .store_data_m    (store_data_m),
        .L_type_m        (L_type_m),
        .S_type_m        (S_type_m),
        .load_unsigned_m (load_unsigned_m),
        .MemRead_m       (MemRead_m),
        .MemWrite_m      (MemWrite_m),
        .regWrite_m      (regWrite_m),
        .MemToReg_m      (MemToReg_m),
        .Rd_M            (Rd_M),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_be         (dmem_be),
        .dmem_rdata      (dmem_rdata),
        .dmem_ready      (dmem_ready),
        .stall_M         (stall_M),
        .read_data_W     (read_data_W),
        .alu_out_W       (alu_out_W),
        .Rd_W            (Rd_W),
        .regWrite_W      (regWrite_W),
        .MemToReg_W      (MemToReg_W),
        .misalign_err    (misalign_err),
        .bus_err         (bus_err)
    );

    task automatic chk32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic chk1(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic drive_idle();
        @(negedge clk);
        alu_out_m = 32'd0; store_data_m = 32'd0; L_type_m = 2'b00; S_type_m = 2'b00;
        load_unsigned_m = 1'b0; MemRead_m = 1'b0; MemWrite_m = 1'b0;
        regWrite_m = 1'b0; MemToReg_m = 1'b0; Rd_M = 5'd0;
        dmem_rdata = 32'd0; dmem_ready = 1'b0;
        #1;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [1:0] lt, input logic uns,
                              input logic [4:0] rd, input logic [31:0] rdata, input logic rdy);
        @(negedge clk);
        alu_out_m = addr; store_data_m = 32'd0; L_type_m = lt; S_type_m = 2'b00;
        load_unsigned_m = uns; MemRead_m = 1'b1; MemWrite_m = 1'b0;
        regWrite_m = 1'b1; MemToReg_m = 1'b1; Rd_M = rd;
        dmem_rdata = rdata; dmem_ready = rdy;
        #1;
    endtask

    task automatic drive_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] st);
        @(negedge clk);
        alu_out_m = addr; store_data_m = data; L_type_m = 2'b00; S_type_m = st;
        load_unsigned_m = 1'b0; MemRead_m = 1'b0; MemWrite_m = 1'b1;
        regWrite_m = 1'b0; MemToReg_m = 1'b0; Rd_M = 5'd0;
        dmem_rdata = 32'hFFFF_FFFF; dmem_ready = 1'b1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive_idle();
        tick();
        // Reset state
        chk32("rst read_data_W", read_data_W, 32'd0);
        chk32("rst alu_out_W", alu_out_W, 32'd0);
        chk32("rst Rd_W", {27'd0, Rd_W}, 32'd0);
        chk1("rst regWrite_W", regWrite_W, 1'b0);
        chk1("rst MemToReg_W", MemToReg_W, 1'b0);
        chk1("rst misalign_err", misalign_err, 1'b0);
        chk1("rst bus_err", bus_err, 1'b0);
        chk1("rst stall_M", stall_M, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait word load
        drive_load(32'h0000_0100, 2'b10, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b1);
        chk1("lw0 stall_M", stall_M, 1'b0);
        chk1("lw0 dmem_req", dmem_req, 1'b1);
        chk1("lw0 dmem_we", dmem_we, 1'b0);
        chk32("lw0 dmem_addr", dmem_addr, 32'h0000_0100);
        tick();
        chk32("lw0 read_data_W", read_data_W, 32'hDEAD_BEEF);
        chk1("lw0 regWrite_W", regWrite_W, 1'b1);
        chk1("lw0 MemToReg_W", MemToReg_W, 1'b1);
        chk32("lw0 Rd_W", {27'd0, Rd_W}, 32'd5);

        // Signed and unsigned byte loads from the top lane
        drive_load(32'h0000_0103, 2'b00, 1'b0, 5'd6, 32'h8000_0000, 1'b1);
        chk32("lb dmem_addr", dmem_addr, 32'h0000_0100);
        tick();
        chk32("lb read_data_W", read_data_W, 32'hFFFF_FF80);
        drive_load(32'h0000_0103, 2'b00, 1'b1, 5'd6, 32'h8000_0000, 1'b1);
        tick();
        chk32("lbu read_data_W", read_data_W, 32'h0000_0080);

        // Signed half load from the upper lane
        drive_load(32'h0000_0042, 2'b01, 1'b0, 5'd9, 32'h8001_7FFF, 1'b1);
        tick();
        chk32("lh read_data_W", read_data_W, 32'hFFFF_8001);

        // Half store at 0x102
        drive_store(32'h0000_0102, 32'hABCD_1234, 2'b01);
        chk32("sh dmem_be", {28'd0, dmem_be}, 32'h0000_000C);
        chk32("sh dmem_wdata", dmem_wdata, 32'h1234_1234);
        chk1("sh dmem_we", dmem_we, 1'b1);
        chk1("sh stall_M", stall_M, 1'b0);
        tick();
        chk32("sh read_data_W held", read_data_W, 32'hFFFF_8001);
        chk1("sh regWrite_W", regWrite_W, 1'b0);

        // Byte store at 0x101
        drive_store(32'h0000_0101, 32'h0000_00A5, 2'b00);
        chk32("sb dmem_be", {28'd0, dmem_be}, 32'h0000_0002);
        chk32("sb dmem_wdata", dmem_wdata, 32'hA5A5_A5A5);

        // Read and write together: the write proceeds, read data is not captured
        drive_load(32'h0000_0200, 2'b10, 1'b0, 5'd3, 32'h5555_5555, 1'b1);
        MemWrite_m = 1'b1; S_type_m = 2'b10; store_data_m = 32'h0F0F_0F0F;
        #1;
        chk1("rw dmem_we", dmem_we, 1'b1);
        chk32("rw dmem_wdata", dmem_wdata, 32'h0F0F_0F0F);
        tick();
        chk32("rw read_data_W held", read_data_W, 32'hFFFF_8001);

        // Load with three not-ready cycles
        drive_load(32'h0000_0204, 2'b10, 1'b0, 5'd10, 32'h0000_0000, 1'b0);
        chk1("wt stall c0", stall_M, 1'b1);
        tick();
        chk1("wt bubble c0", regWrite_W, 1'b0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk1("wt stall", stall_M, 1'b1);
            chk1("wt dmem_req", dmem_req, 1'b1);
            chk32("wt dmem_addr", dmem_addr, 32'h0000_0204);
            tick();
            chk1("wt bubble", regWrite_W, 1'b0);
            chk1("wt bubble m2r", MemToReg_W, 1'b0);
        end
        @(negedge clk);
        dmem_ready = 1'b1; dmem_rdata = 32'h1122_3344;
        #1;
        chk1("wt stall release", stall_M, 1'b0);
        tick();
        chk32("wt read_data_W", read_data_W, 32'h1122_3344);
        chk1("wt regWrite_W", regWrite_W, 1'b1);
        chk32("wt Rd_W", {27'd0, Rd_W}, 32'd10);
        drive_idle();
        chk1("wt idle stall", stall_M, 1'b0);
        tick();
        chk1("wt single writeback", regWrite_W, 1'b0);

        // Misaligned word load; ready must be ignored
        drive_load(32'h0000_0101, 2'b10, 1'b0, 5'd11, 32'h7777_7777, 1'b1);
        chk1("mis dmem_req", dmem_req, 1'b0);
        chk1("mis stall_M", stall_M, 1'b0);
        tick();
        chk1("mis misalign_err", misalign_err, 1'b1);
        chk1("mis regWrite_W", regWrite_W, 1'b0);
        chk32("mis read_data_W held", read_data_W, 32'h1122_3344);
        drive_idle();
        tick();
        chk1("mis pulse end", misalign_err, 1'b0);

        // Non-memory instruction passes through
        @(negedge clk);
        alu_out_m = 32'hCAFE_0001; Rd_M = 5'd7; regWrite_m = 1'b1; MemToReg_m = 1'b0;
        dmem_ready = 1'b1;
        #1;
        chk1("alu dmem_req", dmem_req, 1'b0);
        tick();
        chk32("alu alu_out_W", alu_out_W, 32'hCAFE_0001);
        chk32("alu Rd_W", {27'd0, Rd_W}, 32'd7);
        chk1("alu regWrite_W", regWrite_W, 1'b1);
        chk32("alu read_data_W held", read_data_W, 32'h1122_3344);

        // Ready never arrives
        drive_load(32'h0000_0300, 2'b10, 1'b0, 5'd12, 32'h0000_0000, 1'b0);
        chk1("to stall c0", stall_M, 1'b1);
        tick();
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k < 15; k++) begin
            @(negedge clk);
            #1;
            chk1("to stall", stall_M, 1'b1);
            tick();
            chk1("to bus_err low", bus_err, 1'b0);
        end
        @(negedge clk);
        #1;
        chk1("to stall released", stall_M, 1'b0);
        tick();
        chk1("to bus_err", bus_err, 1'b1);
        chk1("to bubble", regWrite_W, 1'b0);
        drive_idle();
        chk1("to idle", stall_M, 1'b0);
        tick();
        chk1("to bus_err pulse end", bus_err, 1'b0);
`else
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            #1;
            chk1("nt stall", stall_M, 1'b1);
            chk1("nt bus_err", bus_err, 1'b0);
            tick();
        end
        @(negedge clk);
        dmem_ready = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        #1;
        chk1("nt stall release", stall_M, 1'b0);
        tick();
        chk32("nt read_data_W", read_data_W, 32'h0BAD_F00D);
        chk1("nt regWrite_W", regWrite_W, 1'b1);
        drive_idle();
`endif

        // Reset during WAIT abandons the access
        drive_load(32'h0000_0400, 2'b10, 1'b0, 5'd13, 32'h0000_0000, 1'b0);
        tick();
        @(negedge clk);
        #1;
        chk1("rw wait stall", stall_M, 1'b1);
        rst = 1'b1;
        MemRead_m = 1'b0; regWrite_m = 1'b0; MemToReg_m = 1'b0;
        #1;
        chk1("rstw dmem_req", dmem_req, 1'b0);
        chk1("rstw stall_M", stall_M, 1'b0);
        chk32("rstw read_data_W", read_data_W, 32'd0);
        chk32("rstw alu_out_W", alu_out_W, 32'd0);
        chk1("rstw regWrite_W", regWrite_W, 1'b0);
        chk1("rstw bus_err", bus_err, 1'b0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        tick();
        @(negedge clk);
        #1;
        chk1("rstw no retry", dmem_req, 1'b0);
        chk1("rstw no stall", stall_M, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish before 100000");
        $fatal(1, "bench time limit");
    end

endmodule
